multicycle_ctrl_unit: RTL and testbench
=======================================

Name: multicycle_ctrl_unit

Overview:
Parametrised multicycle MIPS control FSM, the next generation of the current control unit.
- Memory latency is configurable through MEM_WAIT wait states.
- Adds addi, beq, bne, jal, jr and an illegal-instruction flag.
- Drives every control output to a defined value in every state; no x outputs.
- Sits between the IR opcode/funct fields plus the ALU zero flag, and the datapath muxes and register enables.

Parameters:
MEM_WAIT, 2, wait cycles after each memory access (fetch, load, store); legal range 0..7
STATE_W, 6, width of State_out

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, combinational from the current ALU operation
PCWrite  out  1  PC load enable (already qualified by zero for branches)
IorD  out  1  memory address select: 0 = PC, 1 = AluOut
MemReadWrite  out  1  0 = read, 1 = write
IRWrite  out  1  IR load enable
MDRWrite  out  1  MDR load enable
AWrite, BWrite  out  1 each  A and B register load enables
AluOutWrite  out  1  AluOut load enable
RegWrite  out  1  register file write enable
AluSrcA  out  1  0 = PC, 1 = A
AluSrcB  out  2  0 = B, 1 = 4, 2 = signext(imm), 3 = signext(imm)<<2
RegDst  out  2  0 = rt, 1 = rd, 2 = $31
MemtoReg  out  2  0 = AluOut, 1 = MDR, 2 = imm<<16, 3 = PC
PCSource  out  2  0 = ALU result, 1 = AluOut, 2 = jump target, 3 = A
ALUOp  out  3  alu_op_t {LOAD, ADD, SUB, AND, INC, NEG, XOR, COMP}
State_out  out  STATE_W  current state encoding, zero-extended
halted  out  1  1 while in BREAK
illegal  out  1  one-cycle pulse in ILLEGAL

Behaviour:
- Moore FSM. Outputs are a pure decode of state, except PCWrite in BRANCH. Every output defaults to 0 and ALUOp defaults to LOAD.
- Reset: state <= RESET and wait counter <= 0, asynchronously. In RESET all outputs are 0. The cycle after reset deasserts, the FSM goes to FETCH.
- Wait counter: loaded with MEM_WAIT-1 on entry to any *_WAIT state. The state exits when the counter is 0, otherwise it decrements. With MEM_WAIT=0 the *_WAIT states are skipped entirely.
- FETCH: IorD=0, read, AluSrcA=0, AluSrcB=1, ADD, PCSource=0, PCWrite=1 (PC <= PC+4). Next FETCH_WAIT, which holds IorD=0 and read.
- IR_LOAD: IorD=0, read, IRWrite=1.
- DECODE: AWrite=BWrite=1, AluSrcA=0, AluSrcB=3, ADD, AluOutWrite=1 (branch target). Dispatch:
  - opcode 0x00 with funct 0x20/0x22/0x24/0x26 -> ARIT_EXEC
  - funct 0x08 -> JR
  - funct 0x0d -> BREAK
  - funct 0x00 (nop) -> FETCH
  - any other funct -> ILLEGAL
  - opcode 0x08 -> ADDI_EXEC
  - 0x04/0x05 -> BRANCH
  - 0x23/0x2b -> MEM_ADDR
  - 0x0f -> LUI
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - anything else -> ILLEGAL
- ARIT_EXEC: AluSrcA=1, AluSrcB=0, ALUOp from funct (ADD, SUB, AND, XOR), AluOutWrite=1. Next ARIT_WB: RegWrite=1, RegDst=1, MemtoReg=0.
- ADDI_EXEC: AluSrcA=1, AluSrcB=2, ADD, AluOutWrite=1. Next ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0.
- BRANCH: AluSrcA=1, AluSrcB=0, SUB, PCSource=1. PCWrite = zero for beq, ~zero for bne. Next FETCH.
- Loads and stores:
  - MEM_ADDR: AluSrcA=1, AluSrcB=2, ADD, AluOutWrite=1.
  - Load path: MEM_READ (IorD=1, read) -> MEM_READ_WAIT -> MDR_LOAD (IorD=1, MDRWrite=1) -> LOAD_WB (RegWrite=1, RegDst=0, MemtoReg=1).
  - Store path: MEM_WRITE (IorD=1, write) -> MEM_WRITE_WAIT (IorD=1, write) -> FETCH.
- LUI: RegWrite=1, RegDst=0, MemtoReg=2.
- JUMP: PCSource=2, PCWrite=1.
- JAL: RegWrite=1, RegDst=2, MemtoReg=3, PCSource=2, PCWrite=1. The register file captures the old PC+4 at the same edge the PC loads.
- JR: PCSource=3, PCWrite=1.
- LUI, JUMP, JAL and JR each return to FETCH.
- BREAK: halted=1. Self-loop; only reset exits.
- ILLEGAL: illegal=1. Next FETCH.
- Cycle counts, with W = MEM_WAIT:
  - common prefix = W+3
  - R-type/addi = W+5
  - branch/lui/jumps = W+4
  - lw = 2W+7
  - sw = 2W+5
- Reset during any state, including mid-wait, wins over every transition.

Decomposition:
- Package mips_ctrl_pkg: state_t enum, alu_op_t enum, opcode/funct localparams, and the mux-select localparams for AluSrcB, RegDst, MemtoReg and PCSource.
- Sub-module ctrl_wait_counter:
  - 3-bit load/decrement counter.
  - Ports: clock, reset, load, load_val, done.

Test Plan:
- MEM_WAIT=2, add (opcode 0x00, funct 0x20) -> exactly 7 cycles FETCH..ARIT_WB; RegWrite=1 with RegDst=1 only in the last cycle; PCWrite=1 only in the first.
- beq with zero=1, then zero=0 -> PCWrite=1 in BRANCH for the first, 0 for the second; bne gives the inverse; PCSource=1.
- lw with MEM_WAIT=0, then MEM_WAIT=3 -> 7 and 13 cycles; MDRWrite one cycle before RegWrite with MemtoReg=1.
- jal -> RegDst=2, MemtoReg=3, RegWrite=1, PCWrite=1, PCSource=2, all in the same cycle; next state FETCH.
- funct 0x0d -> halted=1 and State_out constant for 20 cycles; reset -> RESET then FETCH, halted=0.
- reset asserted mid MEM_READ_WAIT -> all outputs 0 immediately (async); opcode 0x3f -> illegal pulses for exactly one cycle, then FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS control unit
package mips_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_RESET, ST_FETCH, ST_FETCH_WAIT, ST_IR_LOAD, ST_DECODE,
    ST_ARIT_EXEC, ST_ARIT_WB, ST_ADDI_EXEC, ST_ADDI_WB, ST_BRANCH,
    ST_MEM_ADDR, ST_MEM_READ, ST_MEM_READ_WAIT, ST_MDR_LOAD, ST_LOAD_WB,
    ST_MEM_WRITE, ST_MEM_WRITE_WAIT, ST_LUI, ST_JUMP, ST_JAL, ST_JR,
    ST_BREAK, ST_ILLEGAL
  } state_t;

  typedef enum logic [2:0] {
    ALU_LOAD, ALU_ADD, ALU_SUB, ALU_AND, ALU_INC, ALU_NEG, ALU_XOR, ALU_COMP
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_BREAK = 6'h0d;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_XOR   = 6'h26;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_LUI    = 2'd2;
  localparam logic [1:0] M2R_PC     = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_A      = 2'd3;

  function automatic state_t decode_dispatch(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE:
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_XOR: return ST_ARIT_EXEC;
          FN_JR:    return ST_JR;
          FN_BREAK: return ST_BREAK;
          FN_NOP:   return ST_FETCH;
          default:  return ST_ILLEGAL;
        endcase
      OP_ADDI:        return ST_ADDI_EXEC;
      OP_BEQ, OP_BNE: return ST_BRANCH;
      OP_LW, OP_SW:   return ST_MEM_ADDR;
      OP_LUI:         return ST_LUI;
      OP_J:           return ST_JUMP;
      OP_JAL:         return ST_JAL;
      default:        return ST_ILLEGAL;
    endcase
  endfunction

  function automatic alu_op_t funct_alu(input logic [5:0] fn);
    return fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND : fn == FN_XOR ? ALU_XOR : ALU_ADD;
  endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// ctrl_wait_counter: load/decrement counter timing memory wait states
module ctrl_wait_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       done
);
  logic [2:0] count;
  // load takes priority; otherwise count down and rest at zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count <= 3'd0;
    else if (load) count <= load_val;
    else if (count != 3'd0) count <= count - 3'd1;
  end
  assign done = (count == 3'd0);
endmodule

// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit: Moore control FSM for a multicycle MIPS datapath
module multicycle_ctrl_unit
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int STATE_W  = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemReadWrite,
  output logic               IRWrite,
  output logic               MDRWrite,
  output logic               AWrite,
  output logic               BWrite,
  output logic               AluOutWrite,
  output logic               RegWrite,
  output logic               AluSrcA,
  output logic [1:0]         AluSrcB,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         PCSource,
  output alu_op_t            ALUOp,
  output logic [STATE_W-1:0] State_out,
  output logic               halted,
  output logic               illegal
);
  localparam bit         SKIP_WAIT = (MEM_WAIT == 0);
  localparam logic [2:0] WAIT_INIT = SKIP_WAIT ? 3'd0 : 3'(MEM_WAIT - 1);

  state_t state, state_nx;
  logic   wait_load, wait_done;

  // every memory access state arms the counter for the wait state after it
  assign wait_load = (state == ST_FETCH) || (state == ST_MEM_READ) || (state == ST_MEM_WRITE);

  ctrl_wait_counter u_wait (
    .clock    (clock),
    .reset    (reset),
    .load     (wait_load),
    .load_val (WAIT_INIT),
    .done     (wait_done)
  );

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_RESET;
    else state <= state_nx;
  end

  assign State_out = STATE_W'(state);

  // next state and Moore output decode; PCWrite in BRANCH also looks at zero
  always_comb begin
    state_nx     = state;
    PCWrite      = 1'b0;
    IorD         = 1'b0;
    MemReadWrite = 1'b0;
    IRWrite      = 1'b0;
    MDRWrite     = 1'b0;
    AWrite       = 1'b0;
    BWrite       = 1'b0;
    AluOutWrite  = 1'b0;
    RegWrite     = 1'b0;
    AluSrcA      = 1'b0;
    AluSrcB      = SRCB_B;
    RegDst       = REGDST_RT;
    MemtoReg     = M2R_ALUOUT;
    PCSource     = PCSRC_ALU;
    ALUOp        = ALU_LOAD;
    halted       = 1'b0;
    illegal      = 1'b0;
    case (state)
      ST_RESET: state_nx = ST_FETCH;
      ST_FETCH: begin
        AluSrcB  = SRCB_FOUR;
        ALUOp    = ALU_ADD;
        PCWrite  = 1'b1;
        state_nx = SKIP_WAIT ? ST_IR_LOAD : ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: state_nx = wait_done ? ST_IR_LOAD : ST_FETCH_WAIT;
      ST_IR_LOAD: begin
        IRWrite  = 1'b1;
        state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        AWrite      = 1'b1;
        BWrite      = 1'b1;
        AluSrcB     = SRCB_IMM_SH;
        ALUOp       = ALU_ADD;
        AluOutWrite = 1'b1;
        state_nx    = decode_dispatch(opcode, funct);
      end
      ST_ARIT_EXEC: begin
        AluSrcA     = 1'b1;
        ALUOp       = funct_alu(funct);
        AluOutWrite = 1'b1;
        state_nx    = ST_ARIT_WB;
      end
      ST_ARIT_WB: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RD;
        state_nx = ST_FETCH;
      end
      ST_ADDI_EXEC: begin
        AluSrcA     = 1'b1;
        AluSrcB     = SRCB_IMM;
        ALUOp       = ALU_ADD;
        AluOutWrite = 1'b1;
        state_nx    = ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        RegWrite = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_BRANCH: begin
        AluSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = PCSRC_ALUOUT;
        PCWrite  = (opcode == OP_BNE) ? ~zero : zero;
        state_nx = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        AluSrcA     = 1'b1;
        AluSrcB     = SRCB_IMM;
        ALUOp       = ALU_ADD;
        AluOutWrite = 1'b1;
        state_nx    = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      end
      ST_MEM_READ: begin
        IorD     = 1'b1;
        state_nx = SKIP_WAIT ? ST_MDR_LOAD : ST_MEM_READ_WAIT;
      end
      ST_MEM_READ_WAIT: begin
        IorD     = 1'b1;
        state_nx = wait_done ? ST_MDR_LOAD : ST_MEM_READ_WAIT;
      end
      ST_MDR_LOAD: begin
        IorD     = 1'b1;
        MDRWrite = 1'b1;
        state_nx = ST_LOAD_WB;
      end
      ST_LOAD_WB: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MDR;
        state_nx = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        IorD         = 1'b1;
        MemReadWrite = 1'b1;
        state_nx     = SKIP_WAIT ? ST_FETCH : ST_MEM_WRITE_WAIT;
      end
      ST_MEM_WRITE_WAIT: begin
        IorD         = 1'b1;
        MemReadWrite = 1'b1;
        state_nx     = wait_done ? ST_FETCH : ST_MEM_WRITE_WAIT;
      end
      ST_LUI: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_LUI;
        state_nx = ST_FETCH;
      end
      ST_JUMP: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_JAL: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RA;
        MemtoReg = M2R_PC;
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_JR: begin
        PCSource = PCSRC_A;
        PCWrite  = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_BREAK: halted = 1'b1;
      ST_ILLEGAL: begin
        illegal  = 1'b1;
        state_nx = ST_FETCH;
      end
      default: state_nx = ST_RESET;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// tb_multicycle_ctrl_unit: directed checks on three MEM_WAIT variants (2, 0, 3)
module tb_multicycle_ctrl_unit;
  import mips_ctrl_pkg::*;

  logic       clock, reset, zero;
  logic [5:0] opcode, funct;
  logic       pcw[3], iord[3], mrw[3], irw[3], mdrw[3], aw[3], bw[3], aow[3], regw[3], srca[3], halted[3], illegal[3];
  logic [1:0] srcb[3], regdst[3], m2r[3], pcsrc[3];
  logic [2:0] aluop[3];
  logic [5:0] st[3];

  int checks = 0, errors = 0;
  int n, to, bad, c_pcw, c_regw, c_ill;
  int r_pcw[64], r_regw[64], r_regdst[64], r_m2r[64], r_mdr[64], r_pcsrc[64], r_alu[64], r_ill[64], r_st[64];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_ctrl_unit #(.MEM_WAIT(g == 0 ? 2 : (g == 1 ? 0 : 3)), .STATE_W(6)) u_dut (
      .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .PCWrite(pcw[g]), .IorD(iord[g]), .MemReadWrite(mrw[g]), .IRWrite(irw[g]),
      .MDRWrite(mdrw[g]), .AWrite(aw[g]), .BWrite(bw[g]), .AluOutWrite(aow[g]),
      .RegWrite(regw[g]), .AluSrcA(srca[g]), .AluSrcB(srcb[g]), .RegDst(regdst[g]),
      .MemtoReg(m2r[g]), .PCSource(pcsrc[g]), .ALUOp(aluop[g]), .State_out(st[g]),
      .halted(halted[g]), .illegal(illegal[g])
    );
  end

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int any_out(input int k);
    return int'(pcw[k] | iord[k] | mrw[k] | irw[k] | mdrw[k] | aw[k] | bw[k] | aow[k] | regw[k] | srca[k] | halted[k] | illegal[k])
         + int'(srcb[k] | regdst[k] | m2r[k] | pcsrc[k]) + int'(aluop[k]) + int'(st[k]);
  endfunction

  // reset, then record instance k from the first FETCH until the next FETCH
  task automatic trace(input int k, input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
    reset  = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n = 0; c_pcw = 0; c_regw = 0; c_ill = 0;
    do begin
      r_pcw[n] = int'(pcw[k]); r_regw[n] = int'(regw[k]); r_regdst[n] = int'(regdst[k]);
      r_m2r[n] = int'(m2r[k]); r_mdr[n] = int'(mdrw[k]); r_pcsrc[n] = int'(pcsrc[k]);
      r_alu[n] = int'(aluop[k]); r_ill[n] = int'(illegal[k]); r_st[n] = int'(st[k]);
      c_pcw += int'(pcw[k]); c_regw += int'(regw[k]); c_ill += int'(illegal[k]);
      n++;
      @(negedge clock);
    end while (st[k] != 6'(ST_FETCH) && n < 64);
  endtask

  initial begin
    logic [5:0] br_op[4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
    logic       br_z[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    int         br_exp[4] = '{1, 0, 0, 1};
    clock = 0; reset = 1; opcode = 0; funct = 0; zero = 0;
    @(negedge clock);
    check("reset_state", int'(st[0]), int'(ST_RESET));
    check("reset_outputs", any_out(0), 0);

    trace(0, OP_RTYPE, FN_ADD, 1'b0);
    check("add_w2_cycles", n, 7);
    check("add_first_fetch", r_st[0], int'(ST_FETCH));
    check("add_pcw_first", r_pcw[0], 1);
    check("add_pcw_count", c_pcw, 1);
    check("add_regw_last", r_regw[6], 1);
    check("add_regdst_last", r_regdst[6], 1);
    check("add_regw_count", c_regw, 1);
    check("add_aluop", r_alu[5], int'(ALU_ADD));

    trace(1, OP_RTYPE, FN_SUB, 1'b0);
    check("sub_w0_cycles", n, 5);
    check("sub_aluop", r_alu[3], int'(ALU_SUB));
    trace(2, OP_RTYPE, FN_XOR, 1'b0);
    check("xor_w3_cycles", n, 8);
    check("xor_aluop", r_alu[6], int'(ALU_XOR));
    trace(1, OP_RTYPE, FN_AND, 1'b0);
    check("and_aluop", r_alu[3], int'(ALU_AND));

    for (int i = 0; i < 4; i++) begin
      trace(0, br_op[i], 6'h00, br_z[i]);
      check("branch_cycles", n, 6);
      check("branch_pcw", r_pcw[5], br_exp[i]);
      check("branch_pcsrc", r_pcsrc[5], 1);
    end

    trace(1, OP_LW, 6'h00, 1'b0);
    check("lw_w0_cycles", n, 7);
    check("lw_w0_mdr", r_mdr[5], 1);
    check("lw_w0_regw", r_regw[6], 1);
    check("lw_w0_m2r", r_m2r[6], 1);
    trace(2, OP_LW, 6'h00, 1'b0);
    check("lw_w3_cycles", n, 13);
    check("lw_w3_mdr", r_mdr[11], 1);
    check("lw_w3_regw", r_regw[12], 1);
    check("lw_w3_m2r", r_m2r[12], 1);
    check("lw_w3_regw_count", c_regw, 1);

    trace(0, OP_SW, 6'h00, 1'b0);
    check("sw_w2_cycles", n, 9);
    check("sw_no_regw", c_regw, 0);
    trace(1, OP_SW, 6'h00, 1'b0);
    check("sw_w0_cycles", n, 5);

    trace(0, OP_ADDI, 6'h00, 1'b0);
    check("addi_cycles", n, 7);
    check("addi_regw", r_regw[6], 1);
    check("addi_regdst", r_regdst[6], 0);

    trace(1, OP_LUI, 6'h00, 1'b0);
    check("lui_cycles", n, 4);
    check("lui_m2r", r_m2r[3], 2);
    check("lui_regw", r_regw[3], 1);

    trace(0, OP_JAL, 6'h00, 1'b0);
    check("jal_cycles", n, 6);
    check("jal_regdst", r_regdst[5], 2);
    check("jal_m2r", r_m2r[5], 3);
    check("jal_regw", r_regw[5], 1);
    check("jal_pcw", r_pcw[5], 1);
    check("jal_pcsrc", r_pcsrc[5], 2);

    trace(2, OP_RTYPE, FN_JR, 1'b0);
    check("jr_cycles", n, 7);
    check("jr_pcsrc", r_pcsrc[6], 3);
    check("jr_pcw", r_pcw[6], 1);

    trace(0, OP_J, 6'h00, 1'b0);
    check("j_cycles", n, 6);
    check("j_pcsrc", r_pcsrc[5], 2);

    trace(0, OP_RTYPE, FN_NOP, 1'b0);
    check("nop_cycles", n, 5);

    trace(0, 6'h3f, 6'h00, 1'b0);
    check("illop_cycles", n, 6);
    check("illop_pulse_count", c_ill, 1);
    check("illop_pulse_pos", r_ill[5], 1);
    trace(1, OP_RTYPE, 6'h3f, 1'b0);
    check("illfn_cycles", n, 4);
    check("illfn_pulse_pos", r_ill[3], 1);

    opcode = OP_RTYPE; funct = FN_BREAK;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    to = 0;
    while (st[0] != 6'(ST_BREAK) && to < 30) begin
      @(negedge clock);
      to++;
    end
    check("brk_reach_cycles", to, 5);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!halted[0] || st[0] != 6'(ST_BREAK)) bad++;
    end
    check("brk_held_bad", bad, 0);
    check("brk_halted", int'(halted[0]), 1);
    reset = 1'b1;
    #1;
    check("brk_rst_state", int'(st[0]), int'(ST_RESET));
    check("brk_rst_halted", int'(halted[0]), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("brk_after_fetch", int'(st[0]), int'(ST_FETCH));
    check("brk_after_halted", int'(halted[0]), 0);

    opcode = OP_LW; funct = 6'h00;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    to = 0;
    while (st[0] != 6'(ST_MEM_READ_WAIT) && to < 30) begin
      @(negedge clock);
      to++;
    end
    check("midwait_reached", int'(st[0]), int'(ST_MEM_READ_WAIT));
    check("midwait_iord", int'(iord[0]), 1);
    reset = 1'b1;
    #1;
    check("midwait_rst_state", int'(st[0]), int'(ST_RESET));
    check("midwait_rst_outs", any_out(0), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midwait_after_fetch", int'(st[0]), int'(ST_FETCH));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
